// File: rtl/lc3b_types.sv
// Shared LC-3b types: machine word, fetch-stage state encoding and PC step.
package lc3b_types;

  typedef logic [15:0] lc3b_word;

  typedef enum logic [1:0] {
    IDLE,
    FETCH,
    HOLD,
    DISCARD
  } lc3b_fetch_state;

  localparam lc3b_word LC3B_INSTR_BYTES = 16'd2;

  // Instruction addresses are halfword aligned; bit 0 is forced low.
  function automatic lc3b_word lc3b_align(input lc3b_word addr);
    return {addr[15:1], 1'b0};
  endfunction

endpackage

// File: rtl/lc3b_fetch_skid.sv
// One-entry {ir, pc} buffer that parks a fetched instruction while decode stalls.
module lc3b_fetch_skid
  import lc3b_types::*;
(
  input  logic        clk,
  input  logic        reset_n,
  input  logic        load,
  input  logic        drain,
  input  logic        clear,
  input  logic [15:0] load_ir,
  input  logic [15:0] load_pc,
  output logic        valid,
  output logic [15:0] ir,
  output logic [15:0] pc
);

  logic     valid_q, valid_d;
  lc3b_word ir_q, ir_d;
  lc3b_word pc_q, pc_d;

  always_comb begin
    valid_d = valid_q;
    ir_d    = ir_q;
    pc_d    = pc_q;
    if (clear || drain) begin
      valid_d = 1'b0;
    end else if (load) begin
      valid_d = 1'b1;
      ir_d    = load_ir;
      pc_d    = load_pc;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      valid_q <= 1'b0;
      ir_q    <= '0;
      pc_q    <= '0;
    end else begin
      valid_q <= valid_d;
      ir_q    <= ir_d;
      pc_q    <= pc_d;
    end
  end

  assign valid = valid_q;
  assign ir    = ir_q;
  assign pc    = pc_q;

endmodule

// File: rtl/lc3b_fetch.sv
// LC-3b instruction-fetch stage: PC, I-side read handshake, IF/ID register.
// Define LC3B_FETCH_PERF_EN to add saturating fetched/discarded counters.
module lc3b_fetch
  import lc3b_types::*;
#(
  parameter logic [15:0] RESET_PC = 16'h0000
) (
  input  logic        clk,
  input  logic        reset_n,
  output logic        icache_read,
  output logic [15:0] icache_address,
  input  logic [15:0] icache_rdata,
  input  logic        icache_resp,
  input  logic        stall,
  input  logic        redirect_valid,
  input  logic [15:0] redirect_pc,
  output logic        ifid_valid,
  output logic [15:0] ifid_ir,
  output logic [15:0] ifid_pc
`ifdef LC3B_FETCH_PERF_EN
  ,
  output logic [15:0] perf_fetched,
  output logic [15:0] perf_discarded
`endif
);

  lc3b_fetch_state state_q, state_d;
  lc3b_word        pc_q, pc_d;
  lc3b_word        pending_pc_q, pending_pc_d;
  logic            ifid_valid_q, ifid_valid_d;
  lc3b_word        ifid_ir_q, ifid_ir_d;
  lc3b_word        ifid_pc_q, ifid_pc_d;

  logic            hold_load, hold_drain, hold_clear;
  logic            hold_valid;
  lc3b_word        hold_ir, hold_pc;
  logic            slot_free;
  lc3b_word        next_pc;

  assign slot_free = !ifid_valid_q || !stall;
  assign next_pc   = pc_q + LC3B_INSTR_BYTES;

  lc3b_fetch_skid u_skid (
    .clk     (clk),
    .reset_n (reset_n),
    .load    (hold_load),
    .drain   (hold_drain),
    .clear   (hold_clear),
    .load_ir (icache_rdata),
    .load_pc (next_pc),
    .valid   (hold_valid),
    .ir      (hold_ir),
    .pc      (hold_pc)
  );

  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    pending_pc_d = pending_pc_q;
    // A live IF/ID entry is consumed on any edge where decode is not stalled.
    ifid_valid_d = ifid_valid_q && stall;
    ifid_ir_d    = ifid_ir_q;
    ifid_pc_d    = ifid_pc_q;
    hold_load    = 1'b0;
    hold_drain   = 1'b0;
    hold_clear   = 1'b0;

    if (redirect_valid) begin
      ifid_valid_d = 1'b0;
      hold_clear   = 1'b1;
      unique case (state_q)
        FETCH: begin
          if (icache_resp) begin
            pc_d = lc3b_align(redirect_pc);
          end else begin
            // Read must stay stable until its resp, so park the target.
            pending_pc_d = lc3b_align(redirect_pc);
            state_d      = DISCARD;
          end
        end
        DISCARD: begin
          if (icache_resp) begin
            pc_d    = lc3b_align(redirect_pc);
            state_d = FETCH;
          end else begin
            pending_pc_d = lc3b_align(redirect_pc);
          end
        end
        default: begin
          pc_d    = lc3b_align(redirect_pc);
          state_d = FETCH;
        end
      endcase
    end else begin
      unique case (state_q)
        IDLE: state_d = FETCH;
        FETCH: begin
          if (icache_resp) begin
            pc_d = next_pc;
            if (slot_free) begin
              ifid_valid_d = 1'b1;
              ifid_ir_d    = icache_rdata;
              ifid_pc_d    = next_pc;
            end else begin
              hold_load = 1'b1;
              state_d   = HOLD;
            end
          end
        end
        HOLD: begin
          if (!stall && hold_valid) begin
            ifid_valid_d = 1'b1;
            ifid_ir_d    = hold_ir;
            ifid_pc_d    = hold_pc;
            hold_drain   = 1'b1;
            state_d      = FETCH;
          end
        end
        DISCARD: begin
          if (icache_resp) begin
            pc_d    = pending_pc_q;
            state_d = FETCH;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= IDLE;
      pc_q         <= lc3b_align(RESET_PC);
      pending_pc_q <= '0;
      ifid_valid_q <= 1'b0;
      ifid_ir_q    <= '0;
      ifid_pc_q    <= '0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      pending_pc_q <= pending_pc_d;
      ifid_valid_q <= ifid_valid_d;
      ifid_ir_q    <= ifid_ir_d;
      ifid_pc_q    <= ifid_pc_d;
    end
  end

  assign icache_read    = (state_q == FETCH) || (state_q == DISCARD);
  assign icache_address = {pc_q[15:1], 1'b0};
  assign ifid_valid     = ifid_valid_q;
  assign ifid_ir        = ifid_ir_q;
  assign ifid_pc        = ifid_pc_q;

`ifdef LC3B_FETCH_PERF_EN
  logic     fetched_inc, discarded_inc;
  lc3b_word fetched_q, fetched_d;
  lc3b_word discarded_q, discarded_d;

  // Strobes re-derive the IF/ID-load and dropped-resp events of the FSM above.
  always_comb begin
    fetched_inc   = !redirect_valid &&
                    (((state_q == FETCH) && icache_resp && slot_free) ||
                     ((state_q == HOLD) && !stall && hold_valid));
    discarded_inc = icache_resp &&
                    ((state_q == DISCARD) || ((state_q == FETCH) && redirect_valid));
    fetched_d     = fetched_q;
    discarded_d   = discarded_q;
    if (fetched_inc && (fetched_q != '1)) fetched_d = fetched_q + 16'd1;
    if (discarded_inc && (discarded_q != '1)) discarded_d = discarded_q + 16'd1;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      fetched_q   <= '0;
      discarded_q <= '0;
    end else begin
      fetched_q   <= fetched_d;
      discarded_q <= discarded_d;
    end
  end

  assign perf_fetched   = fetched_q;
  assign perf_discarded = discarded_q;
`endif

endmodule

// File: tb/tb_lc3b_fetch.sv
// Scoreboard bench for lc3b_fetch: directed scenarios against a latency-programmable I-memory.
module tb_lc3b_fetch;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        icache_read;
  logic [15:0] icache_address;
  logic [15:0] icache_rdata;
  logic        icache_resp;
  logic        stall;
  logic        redirect_valid;
  logic [15:0] redirect_pc;
  logic        ifid_valid;
  logic [15:0] ifid_ir;
  logic [15:0] ifid_pc;
`ifdef LC3B_FETCH_PERF_EN
  logic [15:0] perf_fetched;
  logic [15:0] perf_discarded;
`endif

  always #5 clk = ~clk;

  lc3b_fetch #(.RESET_PC(16'h0000)) dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .icache_read    (icache_read),
    .icache_address (icache_address),
    .icache_rdata   (icache_rdata),
    .icache_resp    (icache_resp),
    .stall          (stall),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .ifid_valid     (ifid_valid),
    .ifid_ir        (ifid_ir),
    .ifid_pc        (ifid_pc)
`ifdef LC3B_FETCH_PERF_EN
    ,
    .perf_fetched   (perf_fetched),
    .perf_discarded (perf_discarded)
`endif
  );

  typedef struct packed {
    logic [15:0] ir;
    logic [15:0] pc;
  } xfer_t;

  xfer_t exp_q[$];
  int    n_cmp = 0;
  int    n_bad = 0;
  bit    mem_en;
  int    lat;
  int    cnt;

  function automatic logic [15:0] mem_word(input logic [15:0] a);
    case (a)
      16'h0000: return 16'h1234;
      16'h0002: return 16'h5678;
      default:  return a ^ 16'hF0F0;
    endcase
  endfunction

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, required %h", name, act, exp);
    end
  endtask

  task automatic push(input logic [15:0] ir, input logic [15:0] pc);
    xfer_t e;
    e.ir = ir;
    e.pc = pc;
    exp_q.push_back(e);
  endtask

  // Advance one cycle, then let the memory model answer the current request.
  task automatic step();
    @(posedge clk);
    #1;
    if (mem_en && icache_read) begin
      if (cnt >= lat - 1) begin
        icache_resp  = 1'b1;
        icache_rdata = mem_word(icache_address);
        cnt          = 0;
      end else begin
        icache_resp  = 1'b0;
        icache_rdata = 16'h0BAD;
        cnt++;
      end
    end else begin
      icache_resp  = 1'b0;
      icache_rdata = 16'h0BAD;
      cnt          = 0;
    end
  endtask

  initial begin
    xfer_t e;
    forever begin
      @(negedge clk);
      if (reset_n && ifid_valid && !stall) begin
        n_cmp++;
        if (exp_q.size() == 0) begin
          n_bad++;
          $display("FAIL xfer_unexpected: got ir=%h pc=%h, required no transfer", ifid_ir, ifid_pc);
        end else begin
          e = exp_q.pop_front();
          if ((ifid_ir !== e.ir) || (ifid_pc !== e.pc)) begin
            n_bad++;
            $display("FAIL xfer: got ir=%h pc=%h, required ir=%h pc=%h", ifid_ir, ifid_pc, e.ir, e.pc);
          end
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset_n        = 1'b0;
    stall          = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = 16'h0000;
    icache_resp    = 1'b0;
    icache_rdata   = 16'h0000;
    mem_en         = 1'b0;
    lat            = 1;
    cnt            = 0;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check("rst_read", {15'd0, icache_read}, 16'd0);
    check("rst_addr", icache_address, 16'h0000);
    check("rst_valid", {15'd0, ifid_valid}, 16'd0);
    check("rst_ir", ifid_ir, 16'h0000);
    check("rst_pc", ifid_pc, 16'h0000);
    reset_n = 1'b1;

    // Single-cycle memory streaming
    mem_en = 1'b1;
    push(16'h1234, 16'h0002);
    push(16'h5678, 16'h0004);
    step();
    check("s1_read", {15'd0, icache_read}, 16'd1);
    check("s1_addr0", icache_address, 16'h0000);
    step();
    check("s1_addr2", icache_address, 16'h0002);
    mem_en = 1'b0;
    step();
    check("s1_addr4", icache_address, 16'h0004);
    step();
    check("s1_drained", {15'd0, ifid_valid}, 16'd0);

    // Stall during resp parks the word in the hold buffer
    mem_en = 1'b1;
    push(16'hF0F4, 16'h0006);
    push(16'hF0F6, 16'h0008);
    step();
    step();
    mem_en = 1'b0;
    stall  = 1'b1;
    step();
    check("s2_hold_read", {15'd0, icache_read}, 16'd0);
    check("s2_hold_ir", ifid_ir, 16'hF0F4);
    check("s2_hold_pc", ifid_pc, 16'h0006);
    step();
    step();
    check("s2_hold_read3", {15'd0, icache_read}, 16'd0);
    check("s2_hold_valid", {15'd0, ifid_valid}, 16'd1);
    stall = 1'b0;
    step();
    check("s2_resume_read", {15'd0, icache_read}, 16'd1);
    check("s2_resume_addr", icache_address, 16'h0008);
    check("s2_held_ir", ifid_ir, 16'hF0F6);
    step();
    check("s2_drained", {15'd0, ifid_valid}, 16'd0);

    // Redirect while a 3-cycle fetch is outstanding
    lat    = 3;
    mem_en = 1'b1;
    step();
    redirect_valid = 1'b1;
    redirect_pc    = 16'h4000;
    step();
    redirect_valid = 1'b0;
    check("s3_addr_stable", icache_address, 16'h0008);
    check("s3_read_held", {15'd0, icache_read}, 16'd1);
    check("s3_valid0", {15'd0, ifid_valid}, 16'd0);
    step();
    check("s3_addr_at_resp", icache_address, 16'h0008);
    step();
    check("s3_new_addr", icache_address, 16'h4000);
    check("s3_valid0b", {15'd0, ifid_valid}, 16'd0);
    step();
    step();
    push(16'hB0F0, 16'h4002);
    mem_en = 1'b0;
    step();
    check("s3_addr_next", icache_address, 16'h4002);

    // Redirect coincident with resp; bit 0 of the target ignored
    lat    = 1;
    mem_en = 1'b1;
    step();
    redirect_valid = 1'b1;
    redirect_pc    = 16'h4001;
    mem_en         = 1'b0;
    step();
    redirect_valid = 1'b0;
    check("s4_addr", icache_address, 16'h4000);
    check("s4_valid0", {15'd0, ifid_valid}, 16'd0);
    step();
    check("s4_dropped", {15'd0, ifid_valid}, 16'd0);

    // PC wrap at 0xFFFE, entered through DISCARD
    redirect_valid = 1'b1;
    redirect_pc    = 16'hFFFE;
    mem_en         = 1'b1;
    step();
    redirect_valid = 1'b0;
    check("s5_discard_addr", icache_address, 16'h4000);
    step();
    check("s5_addr_fffe", icache_address, 16'hFFFE);
    push(16'h0F0E, 16'h0000);
    push(16'h1234, 16'h0002);
    step();
    check("s5_wrap_addr", icache_address, 16'h0000);
    check("s5_wrap_ifid_pc", ifid_pc, 16'h0000);
    mem_en = 1'b0;
    step();
    step();
`ifdef LC3B_FETCH_PERF_EN
    check("perf_fetched", perf_fetched, 16'd7);
    check("perf_discarded", perf_discarded, 16'd3);
`endif

    // Asynchronous reset mid-fetch, then a stray resp while IDLE
    lat    = 3;
    mem_en = 1'b1;
    step();
    #2;
    reset_n = 1'b0;
    #1;
    check("s6_read", {15'd0, icache_read}, 16'd0);
    check("s6_addr", icache_address, 16'h0000);
    check("s6_valid", {15'd0, ifid_valid}, 16'd0);
    check("s6_ir", ifid_ir, 16'h0000);
    check("s6_pc", ifid_pc, 16'h0000);
`ifdef LC3B_FETCH_PERF_EN
    check("s6_perf_fetched", perf_fetched, 16'd0);
    check("s6_perf_discarded", perf_discarded, 16'd0);
`endif
    step();
    reset_n      = 1'b1;
    mem_en       = 1'b0;
    icache_resp  = 1'b1;
    icache_rdata = 16'hDEAD;
    step();
    check("s6_restart_addr", icache_address, 16'h0000);
    check("s6_restart_read", {15'd0, icache_read}, 16'd1);
    check("s6_stray_ignored", {15'd0, ifid_valid}, 16'd0);
    lat    = 1;
    mem_en = 1'b1;
    push(16'h1234, 16'h0002);
    step();
    mem_en = 1'b0;
    step();
    check("s6_ifid_ir", ifid_ir, 16'h1234);
    step();
`ifdef LC3B_FETCH_PERF_EN
    check("s6_perf_fetched1", perf_fetched, 16'd1);
    check("s6_perf_discarded0", perf_discarded, 16'd0);
`endif

    check("queue_empty", 16'(exp_q.size()), 16'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
